// File: rtl/axi_lite_master_port_if.sv
// ---------------------------------------------------------------------------
// axi_lite_master_port_if
// Bundles every handshake/bus signal of the single-outstanding AXI-Lite
// initiator: the command request port (cmd_*), the response port (rsp_*)
// and the five AXI-Lite channels (m_axi_*).
//   modport master : view taken by axi_lite_master_port (drives cmd_ready,
//                    rsp_*, AXI valids/payloads and bready/rready)
//   modport slave  : opposite view (command source, response sink and the
//                    AXI-Lite register slave)
// ---------------------------------------------------------------------------
interface axi_lite_master_port_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LAT_WIDTH  = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Command request port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;

    // Response port
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic [LAT_WIDTH-1:0]  rsp_latency;

    // AXI-Lite channels
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_latency,
        input  rsp_ready,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_latency,
        output rsp_ready,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi_lite_master_port.sv
// ---------------------------------------------------------------------------
// axi_lite_master_port
// Single-outstanding AXI-Lite initiator. One accepted command becomes one
// AXI-Lite write (AW+W+B) or read (AR+R); the result, together with the
// number of cycles the bus transaction took, is then offered on the
// response port until consumed.
// Ports:
//   aclk     clock, rising edge
//   aresetn  asynchronous active-low reset; abandons any transaction
//   bus      axi_lite_master_port_if.master (cmd_*, rsp_*, m_axi_*)
// All AXI outputs and response outputs come straight from flops; cmd_ready
// is decoded from the state register.
// ---------------------------------------------------------------------------
module axi_lite_master_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LAT_WIDTH  = 8
) (
    input logic                    aclk,
    input logic                    aresetn,
    axi_lite_master_port_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t                state_q,       state_d;
    logic                  awvalid_q,     awvalid_d;
    logic                  wvalid_q,      wvalid_d;
    logic                  bready_q,      bready_d;
    logic                  arvalid_q,     arvalid_d;
    logic                  rready_q,      rready_d;
    logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,       wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,       wstrb_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic                  rsp_write_q,   rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic [1:0]            rsp_resp_q,    rsp_resp_d;
    logic [LAT_WIDTH-1:0]  rsp_latency_q, rsp_latency_d;
    logic [LAT_WIDTH-1:0]  lat_cnt_q,     lat_cnt_d;

    logic                  cmd_ready;
    logic                  aw_pending;
    logic                  w_pending;
    logic [LAT_WIDTH-1:0]  lat_inc;

    // Gated with aresetn so the command port reads as not-ready while the
    // block is held in reset, even though the state register sits at IDLE.
    assign cmd_ready = aresetn && (state_q == IDLE);

    // Saturating increment: counts every cycle spent on the AXI side,
    // including the cycle in which the B/R handshake completes.
    assign lat_inc = (lat_cnt_q == LAT_MAX) ? LAT_MAX : lat_cnt_q + LAT_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_latency_d = rsp_latency_q;
        lat_cnt_d     = lat_cnt_q;
        // A channel is still pending if its valid is up and not being taken now.
        aw_pending    = awvalid_q && !bus.m_axi_awready;
        w_pending     = wvalid_q && !bus.m_axi_wready;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    addr_d    = bus.cmd_addr;
                    lat_cnt_d = '0;
                    if (bus.cmd_write) begin
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // AW and W retire independently; whichever is taken first
                // drops its valid while the other keeps waiting.
                lat_cnt_d = lat_inc;
                awvalid_d = aw_pending;
                wvalid_d  = w_pending;
                if (!aw_pending && !w_pending) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                lat_cnt_d = lat_inc;
                if (bus.m_axi_bvalid && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = bus.m_axi_bresp;
                    rsp_latency_d = lat_inc;
                    state_d       = RSP;
                end
            end

            RD_REQ: begin
                lat_cnt_d = lat_inc;
                if (bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                lat_cnt_d = lat_inc;
                if (bus.m_axi_rvalid && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = bus.m_axi_rdata;
                    rsp_resp_d    = bus.m_axi_rresp;
                    rsp_latency_d = lat_inc;
                    state_d       = RSP;
                end
            end

            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_latency_q <= '0;
            lat_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_latency_q <= rsp_latency_d;
            lat_cnt_q     <= lat_cnt_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_latency   = rsp_latency_q;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master_port.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master_port
// Directed, table-driven bench for axi_lite_master_port. Each table record
// describes one command, how the AXI-Lite slave model delays each channel,
// which response code it returns, and the hand-computed expected response.
// The reset-during-write case is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_axi_lite_master_port;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LW = 8;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    axi_lite_master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) bus ();

    axi_lite_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAT_WIDTH(LW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        logic [1:0]  slv_resp;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_lat;
        int          exp_w_alone;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] mem  [4];
    int          checks = 0;
    int          passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic slave_idle();
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
    endtask

    // Issue one command, play the AXI-Lite slave, then check the response.
    task automatic run_txn(input vec_t v);
        int aw_hs = 0, w_hs = 0, ar_hs = 0;
        int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
        int w_alone = 0;
        bit b_fin = 0, r_fin = 0, got_rsp = 0, stable = 1;
        bit aw_done, w_done, ar_done;
        logic [3:0]  cap_awaddr = '0, cap_araddr = '0;
        logic [31:0] cap_wdata = '0;
        logic [3:0]  cap_wstrb = '0;
        logic [42:0] snap;
        int cyc;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_wstrb = v.wstrb;
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        check({v.name, " cmd_ready"}, bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;

        for (cyc = 0; cyc < 400 && !got_rsp; cyc++) begin
            if (bus.rsp_valid === 1'b1) begin
                got_rsp = 1;
            end else begin
                aw_done = (aw_hs > 0);
                w_done  = (w_hs > 0);
                ar_done = (ar_hs > 0);
                if (bus.m_axi_wvalid === 1'b0 && bus.m_axi_awvalid === 1'b1) w_alone++;
                // AW
                if (bus.m_axi_awvalid === 1'b1) begin
                    if (aw_wait >= v.aw_dly) begin
                        bus.m_axi_awready = 1'b1;
                        aw_hs++;
                        cap_awaddr = bus.m_axi_awaddr;
                    end else bus.m_axi_awready = 1'b0;
                    aw_wait++;
                end else bus.m_axi_awready = 1'b0;
                // W
                if (bus.m_axi_wvalid === 1'b1) begin
                    if (w_wait >= v.w_dly) begin
                        bus.m_axi_wready = 1'b1;
                        w_hs++;
                        cap_wdata = bus.m_axi_wdata;
                        cap_wstrb = bus.m_axi_wstrb;
                    end else bus.m_axi_wready = 1'b0;
                    w_wait++;
                end else bus.m_axi_wready = 1'b0;
                // AR
                if (bus.m_axi_arvalid === 1'b1) begin
                    if (ar_wait >= v.ar_dly) begin
                        bus.m_axi_arready = 1'b1;
                        ar_hs++;
                        cap_araddr = bus.m_axi_araddr;
                    end else bus.m_axi_arready = 1'b0;
                    ar_wait++;
                end else bus.m_axi_arready = 1'b0;
                // B: only after both AW and W have completed
                if (aw_done && w_done && !b_fin) begin
                    if (b_wait >= v.b_dly) begin
                        bus.m_axi_bvalid = 1'b1;
                        bus.m_axi_bresp  = v.slv_resp;
                        if (bus.m_axi_bready === 1'b1) begin
                            b_fin = 1;
                            for (int b = 0; b < 4; b++)
                                if (cap_wstrb[b]) mem[cap_awaddr[3:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                        end
                    end else bus.m_axi_bvalid = 1'b0;
                    b_wait++;
                end else begin
                    bus.m_axi_bvalid = 1'b0;
                    bus.m_axi_bresp  = 2'b00;
                end
                // R: only after AR has completed
                if (ar_done && !r_fin) begin
                    if (r_wait >= v.r_dly) begin
                        bus.m_axi_rvalid = 1'b1;
                        bus.m_axi_rdata  = mem[cap_araddr[3:2]];
                        bus.m_axi_rresp  = v.slv_resp;
                        if (bus.m_axi_rready === 1'b1) r_fin = 1;
                    end else bus.m_axi_rvalid = 1'b0;
                    r_wait++;
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                    bus.m_axi_rdata  = '0;
                    bus.m_axi_rresp  = 2'b00;
                end
                step();
            end
        end
        slave_idle();

        check({v.name, " rsp_valid"}, got_rsp, 1);
        check({v.name, " aw_count"}, aw_hs, v.write ? 1 : 0);
        check({v.name, " w_count"},  w_hs,  v.write ? 1 : 0);
        check({v.name, " ar_count"}, ar_hs, v.write ? 0 : 1);
        if (v.write) begin
            check({v.name, " awaddr"}, cap_awaddr, v.addr);
            check({v.name, " wdata"},  cap_wdata,  v.wdata);
            check({v.name, " wstrb"},  cap_wstrb,  v.wstrb);
            check({v.name, " w_alone_cycles"}, w_alone, v.exp_w_alone);
        end else begin
            check({v.name, " araddr"}, cap_araddr, v.addr);
        end
        check({v.name, " rsp_write"},   bus.rsp_write,   v.write);
        check({v.name, " rsp_rdata"},   bus.rsp_rdata,   v.exp_rdata);
        check({v.name, " rsp_resp"},    bus.rsp_resp,    v.exp_resp);
        check({v.name, " rsp_latency"}, bus.rsp_latency, v.exp_lat);
        $display("txn %s: write=%0d addr=0x%0h rdata=0x%08h resp=%0d latency=%0d",
                 v.name, bus.rsp_write, v.addr, bus.rsp_rdata, bus.rsp_resp, bus.rsp_latency);

        // Response held back: everything must stay frozen, no new traffic.
        snap = {bus.rsp_write, bus.rsp_rdata, bus.rsp_resp, bus.rsp_latency};
        for (int k = 0; k <= v.hold; k++) begin
            if (k > 0) step();
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                {bus.rsp_write, bus.rsp_rdata, bus.rsp_resp, bus.rsp_latency} !== snap ||
                bus.m_axi_awvalid !== 1'b0 || bus.m_axi_wvalid !== 1'b0 ||
                bus.m_axi_arvalid !== 1'b0)
                stable = 0;
        end
        check({v.name, " rsp_hold_stable"}, stable, 1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({v.name, " rsp_done"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rst_view;
        bit         quiet;
        int         cyc;

        // name, wr, addr, wdata, strb, awd, wd, bd, ard, rd, slv_resp, hold,
        // exp_rdata, exp_resp, exp_lat, exp_w_alone
        vecs[0] = '{"wr_cafe",   1'b1, 4'h4, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 0,   2'b00, 0, 32'h0,        2'b00, 8'd3,   0};
        vecs[1] = '{"rd_cafe",   1'b0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 1, 0,   2'b00, 0, 32'hCAFEF00D, 2'b00, 8'd3,   0};
        vecs[2] = '{"wr_ones",   1'b1, 4'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0,   2'b00, 0, 32'h0,        2'b00, 8'd2,   0};
        vecs[3] = '{"wr_w_first",1'b1, 4'h8, 32'h11223344, 4'h3, 3, 0, 1, 0, 0,   2'b00, 0, 32'h0,        2'b00, 8'd6,   3};
        vecs[4] = '{"rd_strb",   1'b0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 0, 0,   2'b00, 5, 32'hFFFF3344, 2'b00, 8'd2,   0};
        vecs[5] = '{"wr_slverr", 1'b1, 4'hC, 32'hA5A5A5A5, 4'hF, 0, 2, 2, 0, 0,   2'b10, 0, 32'h0,        2'b10, 8'd6,   0};
        vecs[6] = '{"rd_decerr", 1'b0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 0, 300, 2'b11, 0, 32'hCAFEF00D, 2'b11, 8'd255, 0};
        vecs[7] = '{"rd_init",   1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 2, 1,   2'b00, 0, 32'h0BADBEEF, 2'b00, 8'd5,   0};
        vecs[8] = '{"wr_post",   1'b1, 4'hC, 32'h12345678, 4'hF, 0, 1, 0, 0, 0,   2'b00, 0, 32'h0,        2'b00, 8'd3,   0};
        vecs[9] = '{"rd_post",   1'b0, 4'hC, 32'h0,        4'h0, 0, 0, 0, 0, 0,   2'b00, 0, 32'h12345678, 2'b00, 8'd2,   0};

        mem[0] = 32'h0BADBEEF;
        mem[1] = 32'h0;
        mem[2] = 32'h0;
        mem[3] = 32'h0;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        bus.rsp_ready = 1'b0;
        slave_idle();

        // Reset state
        step();
        step();
        check("reset_outputs",
              {bus.cmd_ready, bus.rsp_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
               bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready,
               bus.rsp_latency, bus.rsp_rdata, bus.m_axi_awaddr}, 64'h0);
        aresetn = 1'b1;
        #1;
        check("reset_release_cmd_ready", bus.cmd_ready, 1);
        step();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset asserted while a write is outstanding.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'h0;
        bus.cmd_wdata = 32'hDEADDEAD;
        bus.cmd_wstrb = 4'hF;
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        check("rst_mid cmd_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("rst_mid awvalid_before", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b11);
        aresetn = 1'b0;
        #1;
        rst_view = {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                    bus.m_axi_arvalid, bus.m_axi_rready, bus.cmd_ready,
                    bus.rsp_valid, |bus.m_axi_awaddr, |bus.m_axi_wdata, |bus.m_axi_wstrb};
        check("rst_mid outputs_cleared", rst_view, 10'h0);
        step();
        aresetn = 1'b1;
        #1;
        check("rst_mid cmd_ready_after", bus.cmd_ready, 1);
        quiet = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.rsp_valid !== 1'b0 || bus.m_axi_awvalid !== 1'b0 ||
                bus.m_axi_wvalid !== 1'b0 || bus.cmd_ready !== 1'b1)
                quiet = 0;
        end
        check("rst_mid no_response", quiet, 1);
        $display("txn rst_mid: write abandoned by reset");

        for (int i = 8; i < 10; i++) run_txn(vecs[i]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
